// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: recovers a 16-bit hex frame from a scanned, active-low
// seven-segment display bus (4 anodes, 7 cathodes, BASYS3 layout).
// Each digit must hold still for SETTLE_CYCLES before it is captured and decoded.
// Four valid captures make a frame. Value changes only when a frame completes.
// Optional build macro SEG7_DEC_ONLY_EN: when defined, patterns A..F are
// rejected as undecodable (BCD displays); the blank pattern stays valid.
module seg7_scan_decoder #(
    parameter int SETTLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int CNT_W          = 16
) (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [3:0]  An,
    input  logic [6:0]  Seg,
    output logic [15:0] Value,
    output logic        FrameValid,
    output logic [3:0]  DigitValid,
    output logic [3:0]  Blank,
    output logic        PatternErr
);

    typedef enum logic [0:0] {ST_IDLE = 1'b0, ST_COLLECT = 1'b1} state_t;

    localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] SETTLE_PRE = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);

    // Decode result layout: [5] decodable, [4] blank, [3:0] nibble.
    // Pattern p is {a,b,c,d,e,f,g}, active low.
    function automatic logic [5:0] f_decode(input logic [6:0] p);
        logic [5:0] r;
        case (p)
            7'h01:   r = 6'b10_0000;
            7'h4F:   r = 6'b10_0001;
            7'h12:   r = 6'b10_0010;
            7'h06:   r = 6'b10_0011;
            7'h4C:   r = 6'b10_0100;
            7'h24:   r = 6'b10_0101;
            7'h20:   r = 6'b10_0110;
            7'h0F:   r = 6'b10_0111;
            7'h00:   r = 6'b10_1000;
            7'h04:   r = 6'b10_1001;
`ifndef SEG7_DEC_ONLY_EN
            7'h08:   r = 6'b10_1010;
            7'h60:   r = 6'b10_1011;
            7'h31:   r = 6'b10_1100;
            7'h42:   r = 6'b10_1101;
            7'h30:   r = 6'b10_1110;
            7'h38:   r = 6'b10_1111;
`endif
            7'h7F:   r = 6'b11_0000;
            default: r = 6'b00_0000;
        endcase
        return r;
    endfunction

    logic [3:0]       r_an_s1, r_an_s2, r_an_prev;
    logic [6:0]       r_seg_s1, r_seg_s2, r_seg_prev;
    logic [CNT_W-1:0] r_settle;
    logic [CNT_W-1:0] r_tmo;
    state_t           r_state;
    logic [3:0]       r_mask;
    logic [15:0]      r_shadow;
    logic [15:0]      r_value;
    logic             r_frame_valid;
    logic [3:0]       r_digit_valid;
    logic [3:0]       r_blank;
    logic             r_pattern_err;
    logic             r_pend;
    logic [1:0]       r_pend_digit;
    logic [5:0]       r_pend_dec;

    logic             w_same;
    logic             w_capture;
    logic             w_qual;
    logic [1:0]       w_digit;
    logic [6:0]       w_pat;
    logic [5:0]       w_dec;
    logic             w_cap;
    logic             w_src_vld;
    logic [1:0]       w_src_digit;
    logic [5:0]       w_src_dec;

    // Two-flop synchronisers on the anode and cathode lines.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_an_s1  <= 4'hF;
            r_an_s2  <= 4'hF;
            r_seg_s1 <= 7'h7F;
            r_seg_s2 <= 7'h7F;
        end else begin
            r_an_s1  <= An;
            r_an_s2  <= r_an_s1;
            r_seg_s1 <= Seg;
            r_seg_s2 <= r_seg_s1;
        end
    end

    assign w_same    = ({r_an_s2, r_seg_s2} == {r_an_prev, r_seg_prev});
    assign w_capture = w_same && (r_settle == SETTLE_PRE);

    // Settle counter: restarts on any change and saturates so each stable interval captures once.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_an_prev  <= 4'hF;
            r_seg_prev <= 7'h7F;
            r_settle   <= '0;
        end else begin
            r_an_prev  <= r_an_s2;
            r_seg_prev <= r_seg_s2;
            if (!w_same) begin
                r_settle <= '0;
            end else if (r_settle != SETTLE_MAX) begin
                r_settle <= r_settle + CNT_W'(1);
            end else begin
                r_settle <= r_settle;
            end
        end
    end

    // A capture is only meaningful with exactly one anode driven low.
    always_comb begin
        w_qual  = 1'b0;
        w_digit = 2'd0;
        case (r_an_s2)
            4'b1110: begin w_qual = 1'b1; w_digit = 2'd0; end
            4'b1101: begin w_qual = 1'b1; w_digit = 2'd1; end
            4'b1011: begin w_qual = 1'b1; w_digit = 2'd2; end
            4'b0111: begin w_qual = 1'b1; w_digit = 2'd3; end
            default: begin w_qual = 1'b0; w_digit = 2'd0; end
        endcase
    end

    assign w_pat = {r_seg_s2[0], r_seg_s2[1], r_seg_s2[2], r_seg_s2[3],
                    r_seg_s2[4], r_seg_s2[5], r_seg_s2[6]};
    assign w_dec = f_decode(w_pat);
    assign w_cap = w_capture & w_qual;

    // In IDLE a capture deferred by frame completion takes priority over a live one.
    always_comb begin
        w_src_vld   = 1'b0;
        w_src_digit = 2'd0;
        w_src_dec   = 6'd0;
        if (r_pend) begin
            w_src_vld   = 1'b1;
            w_src_digit = r_pend_digit;
            w_src_dec   = r_pend_dec;
        end else begin
            w_src_vld   = w_cap;
            w_src_digit = w_digit;
            w_src_dec   = w_dec;
        end
    end

    // Frame collection FSM with registered outputs.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state       <= ST_IDLE;
            r_mask        <= 4'b0000;
            r_shadow      <= 16'h0000;
            r_value       <= 16'h0000;
            r_frame_valid <= 1'b0;
            r_digit_valid <= 4'b0000;
            r_blank       <= 4'b0000;
            r_pattern_err <= 1'b0;
            r_tmo         <= '0;
            r_pend        <= 1'b0;
            r_pend_digit  <= 2'd0;
            r_pend_dec    <= 6'd0;
        end else begin
            r_frame_valid <= 1'b0;
            r_pattern_err <= 1'b0;
            r_pend        <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_tmo <= '0;
                    if (w_src_vld) begin
                        if (w_src_dec[5]) begin
                            r_shadow[{w_src_digit, 2'b00} +: 4] <= w_src_dec[3:0];
                            r_digit_valid[w_src_digit]          <= 1'b1;
                            r_blank[w_src_digit]                <= w_src_dec[4];
                            r_mask                              <= 4'b0001 << w_src_digit;
                            r_state                             <= ST_COLLECT;
                        end else begin
                            r_pattern_err              <= 1'b1;
                            r_digit_valid[w_src_digit] <= 1'b0;
                        end
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_COLLECT: begin
                    if (r_mask == 4'b1111) begin
                        // Completion wins; a coincident capture is replayed in IDLE.
                        r_value       <= r_shadow;
                        r_frame_valid <= 1'b1;
                        r_mask        <= 4'b0000;
                        r_tmo         <= '0;
                        r_state       <= ST_IDLE;
                        if (w_cap) begin
                            r_pend       <= 1'b1;
                            r_pend_digit <= w_digit;
                            r_pend_dec   <= w_dec;
                        end else begin
                            r_pend <= 1'b0;
                        end
                    end else if (w_cap) begin
                        r_tmo <= '0;
                        if (w_dec[5]) begin
                            r_shadow[{w_digit, 2'b00} +: 4] <= w_dec[3:0];
                            r_digit_valid[w_digit]          <= 1'b1;
                            r_blank[w_digit]                <= w_dec[4];
                            r_mask                          <= r_mask | (4'b0001 << w_digit);
                        end else begin
                            r_pattern_err          <= 1'b1;
                            r_digit_valid[w_digit] <= 1'b0;
                            r_mask                 <= 4'b0000;
                            r_state                <= ST_IDLE;
                        end
                    end else if (r_tmo == TMO_LAST) begin
                        r_mask        <= 4'b0000;
                        r_digit_valid <= 4'b0000;
                        r_blank       <= 4'b0000;
                        r_tmo         <= '0;
                        r_state       <= ST_IDLE;
                    end else begin
                        r_tmo <= r_tmo + CNT_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_mask  <= 4'b0000;
                    r_tmo   <= '0;
                end
            endcase
        end
    end

    assign Value      = r_value;
    assign FrameValid = r_frame_valid;
    assign DigitValid = r_digit_valid;
    assign Blank      = r_blank;
    assign PatternErr = r_pattern_err;

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Recovers hexadecimal digit values from a time-multiplexed, active-low seven-segment display bus (4 anodes + 7 cathodes, BASYS3 layout).
- Inverse of the team's hex-to-seven-segment decoder: it monitors the scanned segment lines, waits for each digit to settle, decodes the pattern back to a nibble and assembles a coherent 16-bit frame.
- Used as an in-design display monitor and checker, and as a self-check tap on the display driver outputs.

Parameters:
SETTLE_CYCLES, 16, consecutive unchanged cycles of the synced {An,Seg} required before a digit is captured (min 2)
TIMEOUT_CYCLES, 65535, cycles without a capture before frame collection aborts
CNT_W, 16, width of the settle and timeout counters (must hold TIMEOUT_CYCLES)

Ports:
Clk  in  1  system clock, rising edge
Reset_n  in  1  asynchronous active-low reset
An  in  4  digit anodes, active low; An[0] = rightmost digit
Seg  in  7  cathodes [0:6] = a..g, active low
Value  out  16  last complete frame; digit i occupies Value[4i+3:4i]
FrameValid  out  1  one-cycle pulse when Value is updated
DigitValid  out  4  bit i = digit i holds a valid code in the current collection
Blank  out  4  bit i = digit i was captured as all-off (0x7F)
PatternErr  out  1  one-cycle pulse on capture of an undecodable pattern

Behaviour:
- Reset: Value=0, FrameValid=0, DigitValid=0, Blank=0, PatternErr=0, counters=0, synchronisers=all-ones, state IDLE.
- Synchronisation: An and Seg each pass through a 2-flop synchroniser.
- Settle counter:
  - Clears when the synced pair differs from the previous cycle.
  - Otherwise increments, saturating at SETTLE_CYCLES.
  - A capture strobe fires only on the cycle the counter reaches SETTLE_CYCLES, so there is exactly one capture per stable interval.
  - Latency from a pin change to the DigitValid/Blank update is SETTLE_CYCLES+3 clocks.
- Capture is qualified: exactly one An bit low. With zero or several low, no capture and no error.
- Decode table (Seg[0] as MSB, 7-bit hex):
  - 0=01, 1=4F, 2=12, 3=06, 4=4C, 5=24, 6=20, 7=0F
  - 8=00, 9=04, A=08, B=60, C=31, D=42, E=30, F=38
  - 7F is a blank: digit nibble = 0, the Blank bit is set, and it counts as valid for frame completion.
  - Any other pattern: PatternErr pulses, the DigitValid bit for that digit clears, and the shadow nibble is unchanged.
- State machine:
  - IDLE: waits for the first valid or blank capture of any digit, then sets that digit's mask bit and goes to COLLECT.
  - COLLECT:
    - Each valid or blank capture writes the shadow nibble and sets the mask bit; a repeat capture overwrites.
    - When the mask reaches 4'b1111, the next cycle copies the shadow to Value, pulses FrameValid, clears the mask and returns to IDLE. DigitValid and Blank hold until overwritten.
    - A PatternErr in COLLECT clears the mask and returns to IDLE.
    - A timeout in COLLECT (TIMEOUT_CYCLES with no capture) clears the mask, DigitValid and Blank, then goes to IDLE; FrameValid does not fire.
- Value changes only on FrameValid, so it never mixes digits from an aborted collection.
- Simultaneous frame completion and a new capture: completion wins; the new capture is processed in IDLE on the following cycle.
- Reset asserted mid-collection clears everything immediately (asynchronous); no FrameValid is emitted.

Optional Feature:
- Macro SEG7_DEC_ONLY_EN.
- Defined: patterns for A..F are treated as undecodable (PatternErr, same handling as above); blank remains valid. Used for BCD displays.
- Undefined: the full 0..F table applies.

Test Plan:
- Static scan: present An=1110/Seg=12, then 1101/06, 1011/4C, 0111/24, each held 20 cycles, SETTLE_CYCLES=16 -> one FrameValid, Value=16'h5432, PatternErr never asserted.
- Glitchy input: toggle Seg every 5 cycles for 40 cycles on a single digit -> no capture. Then hold Seg=01 -> DigitValid[0]=1 exactly SETTLE_CYCLES+3 cycles after the last change.
- Bad pattern: during COLLECT with two digits captured, hold Seg=7E on An=1011 -> single PatternErr pulse, mask cleared, no FrameValid; a subsequent clean scan of 0,1,2,3 -> Value=16'h3210.
- Blank/ghosting: An=0000 held 100 cycles -> no capture. Digit 3 blank (7F), others 8,8,8 -> FrameValid, Value=16'h0888, Blank=4'b1000.
- Timeout/reset: capture digits 0 and 1, then hold An=1111 for TIMEOUT_CYCLES+2 cycles (parameter overridden to 100) -> DigitValid=0, no FrameValid. Assert Reset_n low mid-scan -> all outputs 0 within the same cycle.
- With SEG7_DEC_ONLY_EN defined: scan A,B,C,D (08,60,31,42) -> PatternErr on each capture, Value stays 0.
